// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide adder built from one 4-bit slice reused over
// NIBBLES cycles, least-significant nibble first, with valid/ready on both sides.
// Optional macro NSADD_SUB_EN adds a 'sub' input that turns the add into a - b.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   ci,
`ifdef NSADD_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   co,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_s;
    logic [CW-1:0]   r_count;
    logic            r_carry;
    logic            r_co;
    logic            r_out_valid;
    logic            w_last;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [4:0]      w_slice;
    logic            w_init_carry;

`ifdef NSADD_SUB_EN
    logic            r_sub;
    // Subtract is a + ~b + 1: invert the B nibble, carry-in forced to 1.
    assign w_b_nib      = r_sub ? ~r_b[4*r_count +: 4] : r_b[4*r_count +: 4];
    assign w_init_carry = sub ? 1'b1 : ci;
`else
    assign w_b_nib      = r_b[4*r_count +: 4];
    assign w_init_carry = ci;
`endif

    // The single 4-bit slice; the carry between nibbles lives in r_carry.
    assign w_a_nib = r_a[4*r_count +: 4];
    assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0, r_carry};
    assign w_last  = (r_count == CW'(NIBBLES - 1));

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign co        = r_co;

    // Sequencer: accept operands, walk the slice across nibbles, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_s         <= '0;
            r_co        <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
`ifdef NSADD_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= w_init_carry;
                        r_count <= '0;
                        r_s     <= '0;
`ifdef NSADD_SUB_EN
                        r_sub   <= sub;
`endif
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_s[4*r_count +: 4] <= w_slice[3:0];
                    r_carry             <= w_slice[4];
                    if (w_last) begin
                        r_count     <= '0;
                        r_co        <= w_slice[4];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4, W=16).
module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;
`ifdef NSADD_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, co, busy;
    logic [W-1:0] s;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci),
`ifdef NSADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: the W-bit result plus carry-out as plain wide arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] ma, mb, input logic mci, msub);
        logic [W:0] r;
        if (HAS_SUB && msub) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        else                 r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mci);
        return r;
    endfunction

    // Drives one accept and waits (bounded) for out_valid; out_ready stays low.
    task automatic run_op(input logic [W-1:0] ta, tb_, input logic tci, tsub,
                          output logic [W-1:0] rs, output logic rco, output int lat);
        @(negedge clk);
        a = ta; b = tb_; ci = tci; sub = tsub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rs = s; rco = co;
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || s !== '0 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ov=%b ir=%b busy=%b s=%h co=%b, want 0 1 0 0000 0",
                     out_valid, in_ready, busy, s, co);
        end
        rst = 1'b0;
    endtask

    task automatic test_vector(input string name, input logic [W-1:0] ta, tb_,
                               input logic tci, tsub, input logic [W-1:0] es, input logic eco);
        logic [W-1:0] rs; logic rco; int lat;
        run_op(ta, tb_, tci, tsub, rs, rco, lat);
        n_tests++;
        if (lat !== N) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, N);
        end
        n_tests++;
        if (rs !== es || rco !== eco) begin
            n_fail++; $display("FAIL %s result: got s=%h co=%b want s=%h co=%b", name, rs, rco, es, eco);
        end
        release_op();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s release: ov=%b ir=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] rs; logic rco; int lat;
        run_op(16'h1200, 16'h0034, 1'b0, 1'b0, rs, rco, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || s !== 16'h1234 || co !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure hold %0d: ov=%b s=%h co=%b ir=%b busy=%b want 1 1234 0 0 1",
                         i, out_valid, s, co, in_ready, busy);
            end
        end
        release_op();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL backpressure drop: ov=%b want 0", out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL backpressure ready: ir=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);            // accepted, count=0
        in_valid = 1'b0;
        repeat (2) @(negedge clk); // count=2
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrun busy: busy=%b ir=%b ov=%b want 1 0 0", busy, in_ready, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (s !== '0 || co !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun reset: s=%h co=%b ov=%b busy=%b ir=%b want 0000 0 0 0 1",
                     s, co, out_valid, busy, in_ready);
        end
        test_vector("after_reset", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, rs; logic rci, rsub, rco; logic [W:0] e; int lat, hold;
        for (int k = 0; k < 30; k++) begin
            ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
            rsub = HAS_SUB ? 1'($urandom) : 1'b0;
            if (k == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rci = 1'b1; rsub = 1'b0; end
            e = model(ra, rb, rci, rsub);
            run_op(ra, rb, rci, rsub, rs, rco, lat);
            n_tests++;
            if (lat !== N || rs !== e[W-1:0] || rco !== e[W]) begin
                n_fail++;
                $display("FAIL random %0d: a=%h b=%h ci=%b sub=%b got s=%h co=%b lat=%0d want s=%h co=%b lat=%0d",
                         k, ra, rb, rci, rsub, rs, rco, lat, e[W-1:0], e[W], N);
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                n_tests++;
                if (out_valid !== 1'b1 || s !== e[W-1:0] || co !== e[W]) begin
                    n_fail++;
                    $display("FAIL random hold %0d: ov=%b s=%h co=%b want 1 %h %b", k, out_valid, s, co, e[W-1:0], e[W]);
                end
            end
            release_op();
        end
    endtask

    // in_valid and out_ready held high: results in order, one accept per N+2 cycles.
    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] e;
        int last_acc = -1;
        int n_acc = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b unexpected result s=%h", s);
                end else begin
                    e = q.pop_front();
                    if (s !== e[W-1:0] || co !== e[W]) begin
                        n_fail++; $display("FAIL b2b result: got s=%h co=%b want s=%h co=%b", s, co, e[W-1:0], e[W]);
                    end
                end
            end
            if (cyc < 50) begin
                a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
                sub = HAS_SUB ? 1'($urandom) : 1'b0;
                in_valid = 1'b1;
                if (in_ready) begin
                    q.push_back(model(a, b, ci, sub));
                    if (last_acc >= 0) begin
                        n_tests++;
                        if (cyc - last_acc !== N + 2) begin
                            n_fail++; $display("FAIL b2b spacing: got %0d want %0d", cyc - last_acc, N + 2);
                        end
                    end
                    last_acc = cyc;
                    n_acc++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        n_tests++;
        if (q.size() != 0 || n_acc < 5) begin
            n_fail++; $display("FAIL b2b drain: pending=%0d accepts=%0d want 0 and >=5", q.size(), n_acc);
        end
    endtask

    initial begin
        test_reset();
        test_vector("carry_nibble", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
        test_vector("full_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        test_vector("ci_only",      16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
        test_vector("top_overflow", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
        test_backpressure();
        test_reset_mid_run();
`ifdef NSADD_SUB_EN
        test_vector("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        test_vector("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
        test_vector("sub0_is_add",  16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
